// File: rtl/br_flow_serializer_buffered.sv
`default_nettype none
// ============================================================================
// Module   : br_flow_serializer_buffered
// Purpose  : Registered wide-to-narrow flow serializer. Each accepted push
//            flit is captured into internal storage and sent as up to
//            PushWidth/PopWidth pop flits. Trailing "don't care" slices may
//            be dropped on any flit. Two entries (ACTIVE + NEXT) give full
//            pop throughput with no combinational push->pop or
//            pop_ready->push_ready path.
// Ports    : clk, rst                - clock, synchronous active-high reset
//            push_ready/push_valid   - push handshake
//            push_data               - wide flit (PushWidth)
//            push_last               - last push flit of packet
//            push_dont_care_count    - number of tail slices to drop
//            push_metadata           - sideband, replicated on every pop
//            pop_ready/pop_valid     - pop handshake
//            pop_data                - current slice (PopWidth)
//            pop_last                - final slice of a push_last flit
//            pop_flit_id             - slice index within its push flit
//            pop_metadata            - sideband of the owning push flit
// Revision : 1.0 - initial release
// ============================================================================
module br_flow_serializer_buffered #(
  parameter int PushWidth                     = 2,
  parameter int PopWidth                      = 1,
  parameter int MetadataWidth                 = 1,
  parameter bit SerializeMostSignificantFirst = 1'b1,
  localparam int SR                           = PushWidth / PopWidth,
  localparam int IdW                          = (SR > 1) ? $clog2(SR) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     push_ready,
  input  logic                     push_valid,
  input  logic [PushWidth-1:0]     push_data,
  input  logic                     push_last,
  input  logic [IdW-1:0]           push_dont_care_count,
  input  logic [MetadataWidth-1:0] push_metadata,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output logic [PopWidth-1:0]      pop_data,
  output logic                     pop_last,
  output logic [IdW-1:0]           pop_flit_id,
  output logic [MetadataWidth-1:0] pop_metadata
);

  localparam logic [IdW-1:0] LAST_IDX = IdW'(SR - 1);

  // ACTIVE entry: the flit currently being serialized
  logic                     act_valid;
  logic [PushWidth-1:0]     act_data;
  logic                     act_last;
  logic [IdW-1:0]           act_dcc;
  logic [MetadataWidth-1:0] act_meta;
  logic [IdW-1:0]           idx;

  // NEXT entry: staging slot, only filled while ACTIVE is busy
  logic                     nxt_valid;
  logic [PushWidth-1:0]     nxt_data;
  logic                     nxt_last;
  logic [IdW-1:0]           nxt_dcc;
  logic [MetadataWidth-1:0] nxt_meta;

  logic           push;
  logic           pop;
  logic           at_end;
  logic           done;
  logic [IdW-1:0] idx_sum;

  assign push_ready = !nxt_valid;
  assign push       = push_valid && push_ready;

  assign pop_valid    = act_valid;
  assign pop_metadata = act_meta;
  assign pop_flit_id  = idx;

  // The flit ends once the remaining slices are all don't-care; the sum is
  // kept at IdW bits since idx + dcc never exceeds SR-1.
  assign idx_sum  = idx + act_dcc;
  assign at_end   = (idx_sum == LAST_IDX);
  assign pop_last = act_valid && act_last && at_end;
  assign pop      = pop_valid && pop_ready;
  assign done     = pop && at_end;

  if (SR == 1) begin : g_single
    assign pop_data = act_data;
  end else begin : g_multi
    logic [PopWidth-1:0] slices [SR];
    logic [IdW-1:0]      slice_sel;
    for (genvar i = 0; i < SR; i++) begin : g_slice
      assign slices[i] = act_data[i*PopWidth +: PopWidth];
    end
    // MS-first walks slices downward from the top, so the dropped tail is
    // the low-order end of the flit.
    assign slice_sel = SerializeMostSignificantFirst ? (LAST_IDX - idx) : idx;
    assign pop_data  = slices[slice_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_valid <= 1'b0;
      act_data  <= '0;
      act_last  <= 1'b0;
      act_dcc   <= '0;
      act_meta  <= '0;
      idx       <= '0;
      nxt_valid <= 1'b0;
      nxt_data  <= '0;
      nxt_last  <= 1'b0;
      nxt_dcc   <= '0;
      nxt_meta  <= '0;
    end else begin
      if (done) begin
        idx <= '0;
      end else if (pop) begin
        idx <= idx + IdW'(1);
      end

      if (done && nxt_valid) begin
        // push_ready is low here, so no push can collide with the promotion
        act_valid <= 1'b1;
        act_data  <= nxt_data;
        act_last  <= nxt_last;
        act_dcc   <= nxt_dcc;
        act_meta  <= nxt_meta;
        nxt_valid <= 1'b0;
      end else if ((!act_valid || done) && !nxt_valid) begin
        // ACTIVE free (or freeing this cycle): a push bypasses NEXT
        if (push) begin
          act_valid <= 1'b1;
          act_data  <= push_data;
          act_last  <= push_last;
          act_dcc   <= push_dont_care_count;
          act_meta  <= push_metadata;
        end else if (done) begin
          act_valid <= 1'b0;
        end
      end else if (act_valid && !done && push) begin
        nxt_valid <= 1'b1;
        nxt_data  <= push_data;
        nxt_last  <= push_last;
        nxt_dcc   <= push_dont_care_count;
        nxt_meta  <= push_metadata;
      end
    end
  end

  // Integration checks
  a_width_multiple: assert property (@(posedge clk) (PushWidth % PopWidth) == 0);
  a_pop_width_pos:  assert property (@(posedge clk) PopWidth >= 1 && MetadataWidth >= 1);
  a_dcc_range: assert property (@(posedge clk) disable iff (rst)
    push_valid |-> (32'(push_dont_care_count) < SR));
  a_push_stable: assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=> push_valid);

  // Implementation checks
  a_last_at_end:  assert property (@(posedge clk) disable iff (rst) pop_last |-> at_end);
  a_next_implies: assert property (@(posedge clk) disable iff (rst) nxt_valid |-> act_valid);
  a_id_range:     assert property (@(posedge clk) disable iff (rst) 32'(idx) <= SR - 1);

endmodule
`default_nettype wire

// File: tb/tb_br_flow_serializer_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_flow_serializer_buffered
// Purpose  : Directed self-checking bench for br_flow_serializer_buffered.
//            dut_a: 32->8 MS-first, dut_b: 32->8 LS-first, dut_c: 8->8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_br_flow_serializer_buffered;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // dut_a: MS-first, SR=4
  logic        a_push_ready, a_push_valid, a_push_last, a_pop_ready, a_pop_valid, a_pop_last;
  logic [31:0] a_push_data;
  logic [1:0]  a_push_dcc, a_pop_flit_id;
  logic [3:0]  a_push_meta, a_pop_meta;
  logic [7:0]  a_pop_data;
  // dut_b: LS-first, SR=4
  logic        b_push_ready, b_push_valid, b_push_last, b_pop_ready, b_pop_valid, b_pop_last;
  logic [31:0] b_push_data;
  logic [1:0]  b_push_dcc, b_pop_flit_id;
  logic [3:0]  b_push_meta, b_pop_meta;
  logic [7:0]  b_pop_data;
  // dut_c: SR=1
  logic        c_push_ready, c_push_valid, c_push_last, c_pop_ready, c_pop_valid, c_pop_last;
  logic [7:0]  c_push_data, c_pop_data;
  logic [0:0]  c_push_dcc, c_pop_flit_id;
  logic [3:0]  c_push_meta, c_pop_meta;

  br_flow_serializer_buffered #(.PushWidth(32), .PopWidth(8), .MetadataWidth(4),
                                .SerializeMostSignificantFirst(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .push_ready(a_push_ready), .push_valid(a_push_valid), .push_data(a_push_data),
    .push_last(a_push_last), .push_dont_care_count(a_push_dcc), .push_metadata(a_push_meta),
    .pop_ready(a_pop_ready), .pop_valid(a_pop_valid), .pop_data(a_pop_data),
    .pop_last(a_pop_last), .pop_flit_id(a_pop_flit_id), .pop_metadata(a_pop_meta));

  br_flow_serializer_buffered #(.PushWidth(32), .PopWidth(8), .MetadataWidth(4),
                                .SerializeMostSignificantFirst(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .push_ready(b_push_ready), .push_valid(b_push_valid), .push_data(b_push_data),
    .push_last(b_push_last), .push_dont_care_count(b_push_dcc), .push_metadata(b_push_meta),
    .pop_ready(b_pop_ready), .pop_valid(b_pop_valid), .pop_data(b_pop_data),
    .pop_last(b_pop_last), .pop_flit_id(b_pop_flit_id), .pop_metadata(b_pop_meta));

  br_flow_serializer_buffered #(.PushWidth(8), .PopWidth(8), .MetadataWidth(4),
                                .SerializeMostSignificantFirst(1'b1)) dut_c (
    .clk(clk), .rst(rst),
    .push_ready(c_push_ready), .push_valid(c_push_valid), .push_data(c_push_data),
    .push_last(c_push_last), .push_dont_care_count(c_push_dcc), .push_metadata(c_push_meta),
    .pop_ready(c_pop_ready), .pop_valid(c_pop_valid), .pop_data(c_pop_data),
    .pop_last(c_pop_last), .pop_flit_id(c_pop_flit_id), .pop_metadata(c_pop_meta));

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b1;
    a_push_valid = 1'b1; b_push_valid = 1'b1; c_push_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    a_push_valid = 1'b0; b_push_valid = 1'b0; c_push_valid = 1'b0;
    // {pop_valid, pop_last, pop_flit_id, push_ready}
    got = {a_pop_valid, a_pop_last, a_pop_flit_id, a_push_ready};
    n_cmp++;
    if (got !== 5'b00001) begin n_bad++; $display("FAIL reset_a got %b expected %b", got, 5'b00001); end
    got = {b_pop_valid, b_pop_last, b_pop_flit_id, b_push_ready};
    n_cmp++;
    if (got !== 5'b00001) begin n_bad++; $display("FAIL reset_b got %b expected %b", got, 5'b00001); end
    got = {1'b0, c_pop_valid, c_pop_last, c_pop_flit_id, c_push_ready};
    n_cmp++;
    if (got !== 5'b00001) begin n_bad++; $display("FAIL reset_c got %b expected %b", got, 5'b00001); end
    @(posedge clk); #1;
    n_cmp++;
    if ({a_pop_valid, b_pop_valid, c_pop_valid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_idle got %b expected 000", {a_pop_valid, b_pop_valid, c_pop_valid});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ms_first();
    logic [7:0]  exp_d [4] = '{8'hBA, 8'hAD, 8'hF0, 8'h0D};
    logic [15:0] got, exp_v;
    a_pop_ready = 1'b1;
    a_push_valid = 1'b1; a_push_data = 32'hBAADF00D; a_push_last = 1'b0;
    a_push_dcc = 2'd0; a_push_meta = 4'h3;
    n_cmp++;
    if (a_push_ready !== 1'b1) begin n_bad++; $display("FAIL ms_push_ready got %b expected 1", a_push_ready); end
    @(posedge clk); #1;
    a_push_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got   = {a_pop_valid, a_pop_last, a_pop_flit_id, a_pop_data, a_pop_meta};
      exp_v = {1'b1, 1'b0, 2'(i), exp_d[i], 4'h3};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL ms_pop%0d got %h expected %h", i, got, exp_v); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (a_pop_valid !== 1'b0) begin n_bad++; $display("FAIL ms_drained got %b expected 0", a_pop_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ls_packet();
    logic [7:0]  exp_d [7] = '{8'h67, 8'h45, 8'h23, 8'h01, 8'h0D, 8'hF0, 8'hAD};
    logic [1:0]  exp_id [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [15:0] got, exp_v;
    b_pop_ready = 1'b1;
    b_push_valid = 1'b1; b_push_data = 32'h01234567; b_push_last = 1'b0;
    b_push_dcc = 2'd0; b_push_meta = 4'h2;
    @(posedge clk); #1;
    // top byte of this flit is a dropped tail slice, so its value is irrelevant
    b_push_data = 32'hFFADF00D; b_push_last = 1'b1; b_push_dcc = 2'd1; b_push_meta = 4'h5;
    for (int k = 0; k < 7; k++) begin
      got   = {b_pop_valid, b_pop_last, b_pop_flit_id, b_pop_data, b_pop_meta};
      exp_v = {1'b1, (k == 6), exp_id[k], exp_d[k], (k < 4) ? 4'h2 : 4'h5};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL ls_pop%0d got %h expected %h", k, got, exp_v); end
      if (k == 0) begin
        n_cmp++;
        if (b_push_ready !== 1'b1) begin n_bad++; $display("FAIL ls_stage_ready got %b expected 1", b_push_ready); end
      end
      @(posedge clk); #1;
      if (k == 0) b_push_valid = 1'b0;
    end
    n_cmp++;
    if (b_pop_valid !== 1'b0) begin n_bad++; $display("FAIL ls_drained got %b expected 0", b_pop_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_dcc_nonlast();
    logic [7:0]  exp_d [6] = '{8'h11, 8'h22, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [1:0]  exp_id [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] got, exp_v;
    b_pop_ready = 1'b1;
    b_push_valid = 1'b1; b_push_data = 32'h44332211; b_push_last = 1'b0;
    b_push_dcc = 2'd2; b_push_meta = 4'h1;
    @(posedge clk); #1;
    b_push_data = 32'h88776655; b_push_last = 1'b0; b_push_dcc = 2'd0; b_push_meta = 4'h6;
    for (int k = 0; k < 6; k++) begin
      got   = {b_pop_valid, b_pop_last, b_pop_flit_id, b_pop_data, b_pop_meta};
      exp_v = {1'b1, 1'b0, exp_id[k], exp_d[k], (k < 2) ? 4'h1 : 4'h6};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL dcc_pop%0d got %h expected %h", k, got, exp_v); end
      @(posedge clk); #1;
      if (k == 0) b_push_valid = 1'b0;
    end
    n_cmp++;
    if (b_pop_valid !== 1'b0) begin n_bad++; $display("FAIL dcc_drained got %b expected 0", b_pop_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [31:0] offer_d [3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    logic [7:0]  exp_d [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    logic [15:0] got, exp_v;
    int ptr = 0;
    int ei = 0;
    int last_c = 0;
    bit hs;
    a_pop_ready = 1'b0;
    a_push_valid = 1'b1; a_push_data = offer_d[0]; a_push_last = 1'b0;
    a_push_dcc = 2'd0; a_push_meta = 4'h1;
    hs = a_push_valid && a_push_ready;
    for (int c = 1; c <= 40 && ei < 12; c++) begin
      @(posedge clk); #1;
      if (hs) ptr++;
      if (c >= 2 && c <= 5) begin
        n_cmp++;
        if (a_push_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_c%0d got %b expected 0", c, a_push_ready); end
      end
      got   = {a_pop_valid, a_pop_last, a_pop_flit_id, a_pop_data, a_pop_meta};
      exp_v = {1'b1, (ei == 11), 2'(ei % 4), exp_d[ei], 4'(ei / 4 + 1)};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL bp_c%0d_pop%0d got %h expected %h", c, ei, got, exp_v); end
      a_pop_ready = (c >= 5);
      if (ptr < 3) begin
        a_push_valid = 1'b1; a_push_data = offer_d[ptr];
        a_push_last = (ptr == 2); a_push_meta = 4'(ptr + 1);
      end else begin
        a_push_valid = 1'b0;
      end
      hs = a_push_valid && a_push_ready;
      if (a_pop_valid && a_pop_ready) ei++;
      last_c = c;
    end
    n_cmp++;
    if (ei != 12 || last_c != 16) begin
      n_bad++; $display("FAIL bp_drain got %0d pops in %0d cycles expected 12 in 16", ei, last_c);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({a_pop_valid, a_push_ready} !== 2'b01) begin
      n_bad++; $display("FAIL bp_idle got %b expected 01", {a_pop_valid, a_push_ready});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sr1();
    logic [14:0] got, exp_v;
    int ptr = 0;
    int ei = 0;
    int last_c = 0;
    bit hs;
    c_pop_ready = 1'b1;
    c_push_valid = 1'b1; c_push_data = 8'hA0; c_push_last = 1'b0;
    c_push_dcc = 1'b0; c_push_meta = 4'h0;
    hs = c_push_valid && c_push_ready;
    for (int c = 1; c <= 30 && ei < 6; c++) begin
      @(posedge clk); #1;
      if (hs) ptr++;
      if (c <= 3) begin
        n_cmp++;
        if (c_push_ready !== 1'b1) begin n_bad++; $display("FAIL sr1_ready_c%0d got %b expected 1", c, c_push_ready); end
      end
      got   = {c_pop_valid, c_pop_last, c_pop_flit_id, c_pop_data, c_pop_meta};
      exp_v = {1'b1, (ei == 5), 1'b0, 8'(8'hA0 + ei), 4'(ei)};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("FAIL sr1_c%0d_pop%0d got %h expected %h", c, ei, got, exp_v); end
      c_pop_ready = (c != 3);
      if (ptr < 6) begin
        c_push_valid = 1'b1; c_push_data = 8'(8'hA0 + ptr);
        c_push_last = (ptr == 5); c_push_meta = 4'(ptr);
      end else begin
        c_push_valid = 1'b0;
      end
      hs = c_push_valid && c_push_ready;
      if (c_pop_valid && c_pop_ready) ei++;
      last_c = c;
    end
    n_cmp++;
    if (ei != 6 || last_c != 7) begin
      n_bad++; $display("FAIL sr1_rate got %0d pops in %0d cycles expected 6 in 7", ei, last_c);
    end
    c_pop_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (c_pop_valid !== 1'b0) begin n_bad++; $display("FAIL sr1_drained got %b expected 0", c_pop_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [15:0] got, exp_v;
    a_pop_ready = 1'b1;
    a_push_valid = 1'b1; a_push_data = 32'hDEADBEEF; a_push_last = 1'b1;
    a_push_dcc = 2'd0; a_push_meta = 4'h9;
    @(posedge clk); #1;
    a_push_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got   = {a_pop_valid, a_pop_last, a_pop_flit_id, a_pop_data, a_pop_meta};
    exp_v = {1'b1, 1'b0, 2'd2, 8'hBE, 4'h9};
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL rmid_pre got %h expected %h", got, exp_v); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({a_pop_valid, a_pop_last, a_pop_flit_id, a_push_ready} !== 5'b00001) begin
      n_bad++; $display("FAIL rmid_after got %b expected 00001", {a_pop_valid, a_pop_last, a_pop_flit_id, a_push_ready});
    end
    a_push_valid = 1'b1; a_push_data = 32'hCAFE1234; a_push_last = 1'b0; a_push_meta = 4'h4;
    @(posedge clk); #1;
    a_push_valid = 1'b0;
    got   = {a_pop_valid, a_pop_last, a_pop_flit_id, a_pop_data, a_pop_meta};
    exp_v = {1'b1, 1'b0, 2'd0, 8'hCA, 4'h4};
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL rmid_new0 got %h expected %h", got, exp_v); end
    @(posedge clk); #1;
    got   = {a_pop_valid, a_pop_last, a_pop_flit_id, a_pop_data, a_pop_meta};
    exp_v = {1'b1, 1'b0, 2'd1, 8'hFE, 4'h4};
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL rmid_new1 got %h expected %h", got, exp_v); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (a_pop_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_drained got %b expected 0", a_pop_valid); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    a_push_valid = 1'b0; a_push_data = '0; a_push_last = 1'b0; a_push_dcc = '0;
    a_push_meta = '0; a_pop_ready = 1'b0;
    b_push_valid = 1'b0; b_push_data = '0; b_push_last = 1'b0; b_push_dcc = '0;
    b_push_meta = '0; b_pop_ready = 1'b0;
    c_push_valid = 1'b0; c_push_data = '0; c_push_last = 1'b0; c_push_dcc = '0;
    c_push_meta = '0; c_pop_ready = 1'b0;

    test_reset();
    test_ms_first();
    test_ls_packet();
    test_dcc_nonlast();
    test_backpressure();
    test_sr1();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
